serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Bit-serial counterpart of the team's parallel N-bit magnitude comparator. Two N-bit operands a and b arrive one bit pair per accepted beat, MSB first, over a valid/ready stream. After all N bit pairs are consumed, the block reports lesser/greater/equal for a versus b. It sits at the receiving end of serial links where parallel operands are not available.

Parameters:
n, 16, operand width in bits; legal range 1..1024.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  begin a new comparison frame; honoured only in IDLE or DONE.
a_bit  input  1  current bit of operand a, MSB first.
b_bit  input  1  current bit of operand b, MSB first.
bit_valid  input  1  a_bit/b_bit are valid this cycle.
bit_ready  output  1  block accepts a bit pair this cycle; equals (state==COMPARE).
busy  output  1  high in COMPARE.
done  output  1  one-cycle pulse; flags valid from this cycle.
lesser  output  1  a < b.
greater  output  1  a > b.
equal  output  1  a == b.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. rst has priority over all other inputs.
- Reset values: state=IDLE, bit counter=0, decided=0, lesser=0, greater=0, equal=0, done=0, busy=0, bit_ready=0.
- States: IDLE, COMPARE, DONE.
- IDLE:
  - start=1: next state COMPARE; clear lesser/greater/equal, decided and the counter.
  - bit_valid is ignored.
- COMPARE:
  - Beat acceptance: a beat is accepted when bit_valid && bit_ready.
  - bit_valid=0 stalls. Counter and decision hold; there is no timeout.
  - On an accepted beat with decided=0 and a_bit != b_bit: set decided=1, latch the direction internally (a_bit=1 means greater, otherwise lesser).
  - Bits after the first difference are still consumed and counted, which preserves frame alignment. They do not change the decision.
  - Counter increments per accepted beat. Width is $clog2(n+1), so no wrap occurs for any legal n.
  - On the accepted beat that is the n-th bit: next state DONE.
  - start is ignored in COMPARE; it neither restarts nor aborts the frame.
- DONE (exactly one cycle):
  - done=1.
  - Exactly one of lesser/greater/equal is 1. equal=1 if and only if decided=0 after n bits.
  - Next state is IDLE, or COMPARE if start=1 in this cycle; a start here clears the flags on entry to COMPARE.
- Flag holding: flags hold their last result through IDLE until the next start is honoured. All three flags are 0 while in COMPARE.
- Latency:
  - From start: the first beat can be accepted in the cycle after start.
  - done asserts in the cycle after the n-th beat is accepted.
  - Minimum frame is n+1 cycles from the first accept to done, i.e. n+2 cycles including start.
- Back-to-back frames: start in DONE gives zero idle gap; the next frame's first beat can be accepted the cycle after DONE.
- n=1: a single beat decides the result; DONE follows in the next cycle.
- Reset mid-frame: the next cycle is IDLE with all outputs 0. The partial frame is discarded.
- Outputs are registered, except bit_ready and busy, which are decoded from the state register. There are no combinational paths from inputs to outputs.

Test Plan:
- Equal operands: n=16, after reset, start, stream a=b=0xA5C3 with bit_valid held high -> done at the cycle after beat 16; equal=1, lesser=0, greater=0; flags hold in IDLE until the next start.
- MSB decides greater: a=0x8000, b=0x7FFF -> greater=1 latched at beat 1. The remaining 15 beats are still consumed (bit_ready stays high), then done=1 with greater=1, lesser=0.
- LSB decides lesser with stalls: a=0x0001, b=0x0002, bit_valid toggled 1,0,0,1,... -> counter advances only on valid beats; done after the 16th accepted beat; lesser=1.
- Back-to-back: start asserted in the DONE cycle, then a=0x1234, b=0x1235 -> next frame enters COMPARE with flags cleared and no idle gap; second result lesser=1.
- Reset mid-frame: rst=1 after 7 beats -> next cycle IDLE with every output 0. A following full frame 0xFFFF vs 0x0000 gives greater=1.
- Ignored start and n=1:
  - start pulsed during COMPARE -> no effect on count or result.
  - Separate n=1 instance: a_bit=0, b_bit=1 -> done two cycles after start (one beat, then DONE), lesser=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: consumes n bit pairs of a and b, MSB first,
// over a valid/ready stream and reports lesser/greater/equal once the frame ends.
//
// state   | meaning
// IDLE    | waiting for start; flags hold the last result
// COMPARE | accepting bit pairs, bit_ready high
// DONE    | one-cycle result pulse; start here chains straight into COMPARE
module serial_magnitude_comparator #(
  parameter int n = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  input  logic bit_valid,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic lesser,
  output logic greater,
  output logic equal
);

  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] last_idx = cw'(n - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t          state, next_state;
  logic [cw-1:0]   cnt;
  logic            decided;
  logic            dir_gt;
  logic            accept;
  logic            last_beat;
  logic            decided_nxt;
  logic            dir_gt_nxt;
  logic            frame_start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept      = bit_valid && (state == COMPARE);
    last_beat   = accept && (cnt == last_idx);
    // the first differing bit pair fixes the direction; later bits only keep alignment
    decided_nxt = decided | (a_bit ^ b_bit);
    dir_gt_nxt  = decided ? dir_gt : a_bit;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state  = COMPARE;
          frame_start = 1'b1;
        end
      end
      COMPARE: begin
        if (last_beat) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          next_state  = COMPARE;
          frame_start = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      decided <= 1'b0;
      dir_gt  <= 1'b0;
      done    <= 1'b0;
      lesser  <= 1'b0;
      greater <= 1'b0;
      equal   <= 1'b0;
    end else begin
      done <= last_beat;
      if (frame_start) begin
        cnt     <= '0;
        decided <= 1'b0;
        dir_gt  <= 1'b0;
        lesser  <= 1'b0;
        greater <= 1'b0;
        equal   <= 1'b0;
      end else if (accept) begin
        cnt     <= cnt + cw'(1);
        decided <= decided_nxt;
        dir_gt  <= dir_gt_nxt;
        if (last_beat) begin
          greater <= decided_nxt & dir_gt_nxt;
          lesser  <= decided_nxt & ~dir_gt_nxt;
          equal   <= ~decided_nxt;
        end
      end
    end
  end

  assign bit_ready = (state == COMPARE);
  assign busy      = (state == COMPARE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: an n=16 instance for frame-level
// behaviour and an n=1 instance for the single-beat case.
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst;
  logic start, a_bit, b_bit, bit_valid;
  logic bit_ready, busy, done, lesser, greater, equal;
  logic start1, a_bit1, b_bit1, bit_valid1;
  logic bit_ready1, busy1, done1, lesser1, greater1, equal1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.n(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_bit(a_bit), .b_bit(b_bit),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy), .done(done),
    .lesser(lesser), .greater(greater), .equal(equal)
  );

  serial_magnitude_comparator #(.n(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_bit(a_bit1), .b_bit(b_bit1),
    .bit_valid(bit_valid1), .bit_ready(bit_ready1), .busy(busy1), .done(done1),
    .lesser(lesser1), .greater(greater1), .equal(equal1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid every cycle, 1: valid pattern 1,0,0 repeating, 2: start pulse mid-frame
  task automatic frame16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int mode, input logic [2:0] exp_lge);
    int i;
    int cyc;
    logic v;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_clr"}, {29'd0, lesser, greater, equal}, 32'd0);
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 200) begin
      v = (mode == 1) ? ((cyc % 3) == 0) : 1'b1;
      start = (mode == 2) && (cyc == 5);
      a_bit = a[15 - i];
      b_bit = b[15 - i];
      bit_valid = v;
      tick();
      if (v) i++;
      cyc++;
      if (i < 16) begin
        chk({tag, "_rdy"}, {31'd0, bit_ready}, 32'd1);
        chk({tag, "_mid"}, {28'd0, done, lesser, greater, equal}, 32'd0);
      end
    end
    start = 1'b0;
    bit_valid = 1'b0;
    chk({tag, "_beats"}, i, 32'd16);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_res"}, {29'd0, lesser, greater, equal}, {29'd0, exp_lge});
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; a_bit = 1'b0; b_bit = 1'b0; bit_valid = 1'b0;
    start1 = 1'b0; a_bit1 = 1'b0; b_bit1 = 1'b0; bit_valid1 = 1'b0;
    tick();
    tick();
    chk("rst_out", {26'd0, bit_ready, busy, done, lesser, greater, equal}, 32'd0);
    chk("rst_out1", {26'd0, bit_ready1, busy1, done1, lesser1, greater1, equal1}, 32'd0);
    rst = 1'b0;
    bit_valid = 1'b1;
    tick();
    chk("idle_ignore_valid", {29'd0, bit_ready, busy, done}, 32'd0);
    bit_valid = 1'b0;

    // {lesser, greater, equal}
    frame16("eq", 16'hA5C3, 16'hA5C3, 0, 3'b001);
    tick();
    chk("eq_pulse", {31'd0, done}, 32'd0);
    tick();
    tick();
    chk("eq_hold", {28'd0, busy, lesser, greater, equal}, 32'd1);

    frame16("msb_gt", 16'h8000, 16'h7FFF, 0, 3'b010);
    tick();

    frame16("lsb_lt", 16'h0001, 16'h0002, 1, 3'b100);
    frame16("b2b", 16'h1234, 16'h1235, 0, 3'b100);
    tick();

    frame16("start_ign", 16'h0F00, 16'h0E00, 2, 3'b010);
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    a_bit = 1'b1;
    b_bit = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    bit_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst", {26'd0, bit_ready, busy, done, lesser, greater, equal}, 32'd0);
    frame16("post_rst", 16'hFFFF, 16'h0000, 0, 3'b010);
    tick();

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("n1_rdy", {31'd0, bit_ready1}, 32'd1);
    a_bit1 = 1'b0;
    b_bit1 = 1'b1;
    bit_valid1 = 1'b1;
    tick();
    bit_valid1 = 1'b0;
    chk("n1_done", {31'd0, done1}, 32'd1);
    chk("n1_res", {29'd0, lesser1, greater1, equal1}, 32'd4);
    tick();
    chk("n1_idle", {29'd0, busy1, done1, lesser1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
